// File: rtl/proj1_pkg.sv
// Shared constants for proj1_dual_unit: active-low seven-segment patterns and SW field positions.
package proj1_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam logic [7:0] SEG_TABLE [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    localparam logic [7:0] SEG_GLYPH_G = 8'hC2;
    localparam logic [7:0] SEG_GLYPH_L = 8'hC7;
    localparam logic [7:0] SEG_GLYPH_E = 8'h86;

    localparam int MODE_BIT = 9;
    localparam int A_HI     = 7;
    localparam int A_LO     = 4;
    localparam int B_HI     = 3;
    localparam int B_LO     = 0;

endpackage

// File: rtl/proj1_dual_unit_if.sv
// Board I/O bundle for proj1_dual_unit: switches and keys in, LEDs and six digits out.
interface proj1_dual_unit_if;
    logic [9:0] SW;
    logic [1:0] KEY;
    logic [9:0] LEDR;
    logic [7:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

    modport master (output SW, KEY, input LEDR, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5);
    modport slave  (input SW, KEY, output LEDR, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5);
endinterface

// File: rtl/seg7_hex_decoder.sv
// Combinational 4-bit value to active-low seven-segment pattern, decimal point off.
module seg7_hex_decoder
    import proj1_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] seg
);
    assign seg = SEG_TABLE[nibble];
endmodule

// File: rtl/proj1_dual_unit.sv
// Board top: SW[9] selects a key-driven 9-bit capture register or a 4-bit comparator.
// Define PROJ1_CMP_GLYPH_EN to show a G/L/E result glyph on HEX5 in comparator mode.
module proj1_dual_unit
    import proj1_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic              CLOCK_50,
    input  logic              RESET,
    proj1_dual_unit_if.slave  io
);
    logic [SYNC_STAGES-1:0][9:0] sw_sync_q, sw_sync_d;
    logic [SYNC_STAGES-1:0][1:0] key_sync_q, key_sync_d;
    logic [SYNC_STAGES-1:0]      settle_q, settle_d;
    logic [1:0]                  key_prev_q, key_prev_d;
    logic [1:0]                  arm_q, arm_d;
    logic [8:0]                  reg_q, reg_d;
    logic [9:0]                  ledr_q, ledr_d;
    logic [5:0][7:0]             hex_q, hex_d;

    logic [9:0]      sw_s;
    logic [1:0]      key_s, press;
    logic            mode;
    logic [3:0]      op_a, op_b;
    logic            gt, eq, lt;
    logic [2:0][3:0] nib;
    logic [2:0][7:0] seg;

    assign sw_s  = sw_sync_q[SYNC_STAGES-1];
    assign key_s = key_sync_q[SYNC_STAGES-1];
    assign mode  = sw_s[MODE_BIT];
    assign op_a  = sw_s[A_HI:A_LO];
    assign op_b  = sw_s[B_HI:B_LO];
    assign gt    = op_a > op_b;
    assign eq    = op_a == op_b;
    assign lt    = op_a < op_b;

    // A key only arms once it has been seen released after the synchronizers
    // refilled from the pin, so a key held through reset never fires.
    assign press = arm_q & key_prev_q & ~key_s;

    always_comb begin
        sw_sync_d  = {sw_sync_q[SYNC_STAGES-2:0], io.SW};
        key_sync_d = {key_sync_q[SYNC_STAGES-2:0], io.KEY};
        settle_d   = {settle_q[SYNC_STAGES-2:0], 1'b1};
        key_prev_d = key_s;
        arm_d      = arm_q | ({2{settle_q[SYNC_STAGES-1]}} & key_s);
        reg_d      = reg_q;
        if (!mode) begin
            if (press[1])      reg_d = '0;
            else if (press[0]) reg_d = sw_s[8:0];
        end
    end

    always_comb begin
        nib[0] = mode ? op_b : reg_q[3:0];
        nib[1] = mode ? op_a : reg_q[7:4];
        nib[2] = {3'b000, reg_q[8]};
    end

    for (genvar i = 0; i < 3; i++) begin : g_dig
        seg7_hex_decoder u_dec (.nibble(nib[i]), .seg(seg[i]));
    end

    always_comb begin
        ledr_d = '0;
        hex_d  = {6{SEG_BLANK}};
        if (mode) begin
            ledr_d[9]   = 1'b1;
            ledr_d[2:0] = {gt, eq, lt};
            hex_d[0]    = seg[0];
            hex_d[1]    = seg[1];
`ifdef PROJ1_CMP_GLYPH_EN
            hex_d[5]    = gt ? SEG_GLYPH_G : (lt ? SEG_GLYPH_L : SEG_GLYPH_E);
`else
            hex_d[5]    = SEG_BLANK;
`endif
        end else begin
            ledr_d[8:0] = reg_q;
            hex_d[2:0]  = seg;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            sw_sync_q  <= '0;
            key_sync_q <= '1;
            settle_q   <= '0;
            key_prev_q <= '1;
            arm_q      <= '0;
            reg_q      <= '0;
            ledr_q     <= '0;
            hex_q      <= {6{SEG_BLANK}};
        end else begin
            sw_sync_q  <= sw_sync_d;
            key_sync_q <= key_sync_d;
            settle_q   <= settle_d;
            key_prev_q <= key_prev_d;
            arm_q      <= arm_d;
            reg_q      <= reg_d;
            ledr_q     <= ledr_d;
            hex_q      <= hex_d;
        end
    end

    assign io.LEDR = ledr_q;
    assign io.HEX0 = hex_q[0];
    assign io.HEX1 = hex_q[1];
    assign io.HEX2 = hex_q[2];
    assign io.HEX3 = hex_q[3];
    assign io.HEX4 = hex_q[4];
    assign io.HEX5 = hex_q[5];

endmodule

// File: tb/tb_proj1_dual_unit.sv
// Directed bench for proj1_dual_unit: reset, capture/clear keys, hold, mode flip, comparator.
module tb_proj1_dual_unit;
    logic clk = 1'b0;
    logic rst;
    int   pass_cnt = 0;
    int   chk_cnt  = 0;

`ifdef PROJ1_CMP_GLYPH_EN
    localparam logic [7:0] EXP_G = 8'hC2, EXP_L = 8'hC7, EXP_E = 8'h86;
`else
    localparam logic [7:0] EXP_G = 8'hFF, EXP_L = 8'hFF, EXP_E = 8'hFF;
`endif

    proj1_dual_unit_if io ();

    proj1_dual_unit #(.SYNC_STAGES(2)) dut (
        .CLOCK_50 (clk),
        .RESET    (rst),
        .io       (io)
    );

    always #10 clk = ~clk;

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_release(input logic [1:0] keys);
        io.KEY = ~keys;
        edges(3);
        io.KEY = 2'b11;
        edges(6);
    endtask

    task automatic test_reset();
        io.SW = 10'h000; io.KEY = 2'b11; rst = 1'b1;
        edges(3);
        chk_cnt++; if (io.LEDR !== 10'h000) $display("FAIL rst_ledr got %h want 000", io.LEDR); else pass_cnt++;
        chk_cnt++; if ({io.HEX0, io.HEX1, io.HEX2, io.HEX3, io.HEX4, io.HEX5} !== {6{8'hFF}})
            $display("FAIL rst_hex got %h%h%h%h%h%h want all FF", io.HEX5, io.HEX4, io.HEX3, io.HEX2, io.HEX1, io.HEX0);
        else pass_cnt++;
        rst = 1'b0;
        edges(4);
        chk_cnt++; if ({io.HEX2, io.HEX1, io.HEX0} !== {3{8'hC0}})
            $display("FAIL post_rst_hex got %h %h %h want C0 C0 C0", io.HEX2, io.HEX1, io.HEX0);
        else pass_cnt++;
        chk_cnt++; if (io.LEDR !== 10'h000 || io.HEX3 !== 8'hFF) $display("FAIL post_rst_ledr got %h/%h want 000/FF", io.LEDR, io.HEX3); else pass_cnt++;
    endtask

    task automatic test_load();
        io.SW = 10'b01_1111_1111;
        edges(4);
        io.KEY = 2'b10;
        edges(3);
        chk_cnt++; if (io.LEDR !== 10'h000) $display("FAIL load_early got %h want 000", io.LEDR); else pass_cnt++;
        edges(1);
        chk_cnt++; if (io.LEDR !== 10'h1FF) $display("FAIL load_4th_edge got %h want 1FF", io.LEDR); else pass_cnt++;
        io.KEY = 2'b11;
        edges(5);
        chk_cnt++; if ({io.HEX2, io.HEX1, io.HEX0} !== {8'hF9, 8'h8E, 8'h8E})
            $display("FAIL load_hex got %h %h %h want F9 8E 8E", io.HEX2, io.HEX1, io.HEX0);
        else pass_cnt++;
        chk_cnt++; if ({io.HEX5, io.HEX4, io.HEX3} !== {3{8'hFF}})
            $display("FAIL load_blank got %h %h %h want FF FF FF", io.HEX5, io.HEX4, io.HEX3);
        else pass_cnt++;
    endtask

    task automatic test_clear();
        press_release(2'b10);
        chk_cnt++; if (io.LEDR !== 10'h000) $display("FAIL clear_k1 got %h want 000", io.LEDR); else pass_cnt++;
        io.SW = 10'h0A5;
        edges(4);
        press_release(2'b01);
        chk_cnt++; if (io.LEDR !== 10'h0A5) $display("FAIL reload got %h want 0A5", io.LEDR); else pass_cnt++;
        chk_cnt++; if ({io.HEX2, io.HEX1, io.HEX0} !== {8'hC0, 8'h88, 8'h92})
            $display("FAIL reload_hex got %h %h %h want C0 88 92", io.HEX2, io.HEX1, io.HEX0);
        else pass_cnt++;
        press_release(2'b11);
        chk_cnt++; if (io.LEDR !== 10'h000) $display("FAIL clear_wins got %h want 000", io.LEDR); else pass_cnt++;
    endtask

    task automatic test_hold();
        io.SW = 10'h123;
        edges(4);
        io.KEY = 2'b10;
        edges(6);
        chk_cnt++; if (io.LEDR !== 10'h123) $display("FAIL hold_cap got %h want 123", io.LEDR); else pass_cnt++;
        io.SW = 10'h0F0;
        edges(8);
        chk_cnt++; if (io.LEDR !== 10'h123) $display("FAIL hold_sw_change got %h want 123", io.LEDR); else pass_cnt++;
        io.KEY = 2'b11;
        edges(6);
        chk_cnt++; if (io.LEDR !== 10'h123) $display("FAIL hold_release got %h want 123", io.LEDR); else pass_cnt++;
        chk_cnt++; if ({io.HEX2, io.HEX1, io.HEX0} !== {8'hF9, 8'hA4, 8'hB0})
            $display("FAIL hold_hex got %h %h %h want F9 A4 B0", io.HEX2, io.HEX1, io.HEX0);
        else pass_cnt++;
    endtask

    task automatic test_mode_flip();
        io.SW = 10'h1FF;
        edges(4);
        press_release(2'b01);
        io.SW = 10'b11_1111_1111;
        edges(2);
        chk_cnt++; if (io.LEDR !== 10'h1FF) $display("FAIL flip_early got %h want 1FF", io.LEDR); else pass_cnt++;
        edges(1);
        chk_cnt++; if (io.LEDR !== 10'h202) $display("FAIL flip_3rd_edge got %h want 202", io.LEDR); else pass_cnt++;
        chk_cnt++; if ({io.HEX2, io.HEX1, io.HEX0} !== {8'hFF, 8'h8E, 8'h8E})
            $display("FAIL flip_hex got %h %h %h want FF 8E 8E", io.HEX2, io.HEX1, io.HEX0);
        else pass_cnt++;
        chk_cnt++; if (io.HEX5 !== EXP_E) $display("FAIL flip_glyph got %h want %h", io.HEX5, EXP_E); else pass_cnt++;
        press_release(2'b10);
        io.SW = 10'h0FF;
        edges(4);
        chk_cnt++; if (io.LEDR !== 10'h1FF) $display("FAIL flip_back got %h want 1FF", io.LEDR); else pass_cnt++;
        chk_cnt++; if (io.HEX5 !== 8'hFF) $display("FAIL flip_back_hex5 got %h want FF", io.HEX5); else pass_cnt++;
    endtask

    task automatic test_compare();
        io.SW = 10'b10_1111_0000; edges(4);
        chk_cnt++; if (io.LEDR !== 10'h204 || io.HEX5 !== EXP_G) $display("FAIL cmp_gt got %h/%h want 204/%h", io.LEDR, io.HEX5, EXP_G); else pass_cnt++;
        chk_cnt++; if ({io.HEX1, io.HEX0} !== {8'h8E, 8'hC0}) $display("FAIL cmp_gt_hex got %h %h want 8E C0", io.HEX1, io.HEX0); else pass_cnt++;
        io.SW = 10'b10_0000_1111; edges(4);
        chk_cnt++; if (io.LEDR !== 10'h201 || io.HEX5 !== EXP_L) $display("FAIL cmp_lt got %h/%h want 201/%h", io.LEDR, io.HEX5, EXP_L); else pass_cnt++;
        io.SW = 10'b10_0011_0011; edges(4);
        chk_cnt++; if (io.LEDR !== 10'h202 || io.HEX5 !== EXP_E) $display("FAIL cmp_eq got %h/%h want 202/%h", io.LEDR, io.HEX5, EXP_E); else pass_cnt++;
        chk_cnt++; if ({io.HEX1, io.HEX0} !== {8'hB0, 8'hB0}) $display("FAIL cmp_eq_hex got %h %h want B0 B0", io.HEX1, io.HEX0); else pass_cnt++;
        io.SW = 10'b11_0110_0111; edges(4);
        chk_cnt++; if (io.LEDR !== 10'h201) $display("FAIL cmp_sw8_ignored got %h want 201", io.LEDR); else pass_cnt++;
        io.SW = 10'b10_1001_0111; edges(4);
        chk_cnt++; if (io.LEDR !== 10'h204) $display("FAIL cmp_msb got %h want 204", io.LEDR); else pass_cnt++;
    endtask

    task automatic test_reset_mid_press();
        io.SW = 10'h055;
        io.KEY = 2'b10;
        edges(2);
        rst = 1'b1;
        edges(2);
        rst = 1'b0;
        edges(8);
        chk_cnt++; if (io.LEDR !== 10'h000) $display("FAIL held_through_rst got %h want 000", io.LEDR); else pass_cnt++;
        io.KEY = 2'b11;
        edges(4);
        press_release(2'b01);
        chk_cnt++; if (io.LEDR !== 10'h055) $display("FAIL repress_after_rst got %h want 055", io.LEDR); else pass_cnt++;
    endtask

    initial begin
        io.SW = '0; io.KEY = 2'b11; rst = 1'b0;
        test_reset();
        test_load();
        test_clear();
        test_hold();
        test_mode_flip();
        test_compare();
        test_reset_mid_press();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/proj1_dual_unit.md
Name: proj1_dual_unit

Overview:
- Board-level top for a 10-switch / 2-key / 6-digit / 10-LED FPGA kit, holding two selectable design units.
- SW[9] selects the unit:
  - 0 = Unit 1, a 9-bit switch-capture register loaded and cleared by pushbuttons.
  - 1 = Unit 2, a 4-bit magnitude comparator.
- All inputs are synchronized and all outputs are registered.
- Seven-segment digits are active-low.

Parameters:
- SYNC_STAGES, 2, synchronizer depth for SW and KEY (minimum 2).

Ports:
- CLOCK_50  in  1  system clock, rising-edge.
- RESET  in  1  asynchronous, active-high reset.
- SW  in  10  slide switches; SW[9] = unit select, SW[8:0] = data.
- KEY  in  2  pushbuttons, active-low (0 = pressed).
- LEDR  out  10  LEDs, active-high.
- HEX0..HEX5  out  8 each  seven-segment digits, active-low; bits[6:0] = segments a..g, bit7 = DP.

Behaviour:
- Reset (asynchronous, active-high):
  - capture register = 0; synchronizers = SW 0, KEY 1; previous-key flops = 1.
  - Outputs: LEDR = 0, HEX0..HEX5 = 8'hFF (blank).
  - Reset deasserted mid-press: no press is detected until KEY is released and pressed again.
- Synchronization: SW and KEY pass through SYNC_STAGES flops.
- Press detection: press = previous synced value 1 and current synced value 0. One pulse per press; holding or releasing a key has no effect.
- Unit 1 (synced SW[9] = 0):
  - KEY[0] press: register <= synced SW[8:0].
  - KEY[1] press: register <= 0.
  - Both pressed in the same cycle: clear wins.
  - LEDR[8:0] = register, LEDR[9] = 0.
  - HEX0 = hex(reg[3:0]), HEX1 = hex(reg[7:4]), HEX2 = hex({3'b0, reg[8]}).
  - HEX3..HEX5 = 8'hFF.
- Unit 2 (synced SW[9] = 1):
  - A = SW[7:4], B = SW[3:0], unsigned; SW[8] is ignored.
  - gt = A>B, eq = A==B, lt = A<B; exactly one is 1.
  - LEDR[9] = 1, LEDR[2] = gt, LEDR[1] = eq, LEDR[0] = lt, LEDR[8:3] = 0.
  - HEX0 = hex(B), HEX1 = hex(A), HEX2..HEX4 = 8'hFF, HEX5 per optional feature.
  - Key presses are ignored; the register holds its value and reappears on return to Unit 1.
- Hex encoding (DP off):
  - 0..7: C0 F9 A4 B0 99 92 82 F8
  - 8..F: 80 90 88 83 C6 A1 86 8E
- Latency (SYNC_STAGES = 2):
  - SW change visible on outputs after the 3rd rising edge.
  - KEY press: register updates on the 3rd edge, outputs on the 4th edge.
- Mode switch: outputs change 3 edges after the SW[9] change; no glitch states.

Optional Feature:
- Macro PROJ1_CMP_GLYPH_EN.
- Defined: in Unit 2, HEX5 shows a result glyph: gt = "G" (8'hC2), lt = "L" (8'hC7), eq = "E" (8'h86).
- Undefined: HEX5 is always 8'hFF.
- Unit 1 behaviour is identical either way.

Decomposition:
- Package proj1_pkg holds:
  - the seven-segment constants: SEG_BLANK = 8'hFF, the 16-entry digit table, and the glyph constants G/L/E;
  - the SW index constants: MODE_BIT = 9, A = [7:4], B = [3:0].
- One sub-module: seg7_hex_decoder, a combinational 4-bit to 8-bit active-low decoder, instantiated once per digit in use.
- Synchronizers and edge detect are inline in the top.

Test Plan:
- Reset: assert RESET with SW = 10'h000 → LEDR = 0 and all HEX = FF during reset; after release with SW[9] = 0 → HEX0..HEX2 = C0 and LEDR = 0.
- Load: SW = 10'b01_1111_1111, press and release KEY[0] → within 4 edges LEDR = 10'h1FF, HEX0 = 8E, HEX1 = 8E, HEX2 = F9, HEX3..HEX5 = FF.
- Clear: press KEY[1], then press KEY[0] and KEY[1] in the same cycle → register = 0 (clear wins).
- Hold: keep KEY[0] pressed while SW changes → register unchanged after the single capture.
- Mode flip: SW = 10'b11_1111_1111 → LEDR = 10'b10_0000_0010 (eq), HEX0 = 8E, HEX1 = 8E; flip back to Unit 1 → LEDR = 10'h1FF restored.
- Compare:
  - SW = 10'b10_1111_0000 → LEDR[2:0] = 100, HEX5 = C2 with the glyph macro;
  - SW = 10'b10_0000_1111 → LEDR[2:0] = 001, HEX5 = C7;
  - SW = 10'b10_0011_0011 → LEDR[2:0] = 010, HEX5 = 86 (FF without the macro).
